// File: rtl/alu_wb_pkg.sv
// Shared definitions for the ALU writeback register file: funct codes,
// funct field width and the result-select enum.
package alu_wb_pkg;

  localparam int FUNCT_W = 6;

  localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FUNCT_SRL = 6'b000010;
  localparam logic [FUNCT_W-1:0] FUNCT_SLL = 6'b000000;
  localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;

  typedef enum logic [2:0] {
    SEL_ADD = 3'd0,
    SEL_SUB = 3'd1,
    SEL_SRL = 3'd2,
    SEL_SLL = 3'd3,
    SEL_AND = 3'd4,
    SEL_OR  = 3'd5
  } alu_sel_t;

endpackage

// File: rtl/alu_result_sel.sv
// Combinational funct decoder and six-way ALU result mux.
// o_legal is low for any funct code outside the six supported ones; the
// value on o_result is then meaningless and must be discarded by the caller.
module alu_result_sel
  import alu_wb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [FUNCT_W-1:0] i_funct,
  input  logic [WIDTH-1:0]   i_res_add,
  input  logic [WIDTH-1:0]   i_res_sub,
  input  logic [WIDTH-1:0]   i_res_srl,
  input  logic [WIDTH-1:0]   i_res_sll,
  input  logic [WIDTH-1:0]   i_res_and,
  input  logic [WIDTH-1:0]   i_res_or,
  output logic [WIDTH-1:0]   o_result,
  output logic               o_legal
);

  alu_sel_t w_sel;

  // Decode funct into a select code and a legality bit.
  always_comb begin
    w_sel   = SEL_ADD;
    o_legal = 1'b0;
    case (i_funct)
      FUNCT_ADD: begin w_sel = SEL_ADD; o_legal = 1'b1; end
      FUNCT_SUB: begin w_sel = SEL_SUB; o_legal = 1'b1; end
      FUNCT_SRL: begin w_sel = SEL_SRL; o_legal = 1'b1; end
      FUNCT_SLL: begin w_sel = SEL_SLL; o_legal = 1'b1; end
      FUNCT_AND: begin w_sel = SEL_AND; o_legal = 1'b1; end
      FUNCT_OR:  begin w_sel = SEL_OR;  o_legal = 1'b1; end
      default:   begin w_sel = SEL_ADD; o_legal = 1'b0; end
    endcase
  end

  // Route the selected unit output.
  always_comb begin
    o_result = '0;
    case (w_sel)
      SEL_ADD: o_result = i_res_add;
      SEL_SUB: o_result = i_res_sub;
      SEL_SRL: o_result = i_res_srl;
      SEL_SLL: o_result = i_res_sll;
      SEL_AND: o_result = i_res_and;
      SEL_OR:  o_result = i_res_or;
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_wb_regfile.sv
// ALU result select, single-entry pending writeback stage, register file
// with two bypassed combinational read ports, and a wrapping commit counter.
//
// Handshake: a bundle is accepted on a rising edge where in_valid && in_ready.
// in_ready = !pending || !wb_hold, so at most one bundle sits in the pending
// stage; a producer seeing in_ready low keeps its bundle stable. The pending
// entry commits on any edge where wb_hold is low, and a new bundle may be
// accepted on that same edge.
//
// Optional build macro ALU_WB_ZERO_REG_EN: register 0 reads as zero, and
// legal writes to it are accepted but silently discarded (no counter bump).
module alu_wb_regfile
  import alu_wb_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NREGS  = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [ADDR_W-1:0]  rd,
  input  logic [WIDTH-1:0]   res_add,
  input  logic [WIDTH-1:0]   res_sub,
  input  logic [WIDTH-1:0]   res_srl,
  input  logic [WIDTH-1:0]   res_sll,
  input  logic [WIDTH-1:0]   res_and,
  input  logic [WIDTH-1:0]   res_or,
  input  logic               wb_hold,
  input  logic [ADDR_W-1:0]  rs_addr,
  input  logic [ADDR_W-1:0]  rt_addr,
  output logic [WIDTH-1:0]   rs_data,
  output logic [WIDTH-1:0]   rt_data,
  output logic               illegal_funct,
  output logic [CNT_W-1:0]   wr_count
);

  // Pending writeback stage and architectural state.
  logic              r_p_valid;
  logic [ADDR_W-1:0] r_p_rd;
  logic [WIDTH-1:0]  r_p_data;
  logic [WIDTH-1:0]  r_regs [NREGS];
  logic              r_illegal;
  logic [CNT_W-1:0]  r_wr_count;

  logic [WIDTH-1:0]  w_sel_result;
  logic              w_funct_legal;
  logic              w_rd_ok;
  logic              w_legal;
  logic              w_accept;
  logic              w_new_entry;
  logic              w_commit;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < NREGS;
  endfunction

  alu_result_sel #(
    .WIDTH (WIDTH)
  ) u_sel (
    .i_funct   (funct),
    .i_res_add (res_add),
    .i_res_sub (res_sub),
    .i_res_srl (res_srl),
    .i_res_sll (res_sll),
    .i_res_and (res_and),
    .i_res_or  (res_or),
    .o_result  (w_sel_result),
    .o_legal   (w_funct_legal)
  );

  // Handshake, legality and commit qualifiers.
  always_comb begin
    in_ready = !r_p_valid || !wb_hold;
    w_rd_ok  = addr_in_range(rd);
    w_legal  = w_funct_legal && w_rd_ok;
    w_accept = in_valid && in_ready;
    w_commit = r_p_valid && !wb_hold;
`ifdef ALU_WB_ZERO_REG_EN
    // Writes to the hardwired zero register are swallowed here.
    w_new_entry = w_accept && w_legal && (rd != '0);
`else
    w_new_entry = w_accept && w_legal;
`endif
  end

  // Pending stage: load on a legal accept, clear on commit, freeze on hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p_valid <= 1'b0;
      r_p_rd    <= '0;
      r_p_data  <= '0;
    end else if (w_new_entry) begin
      r_p_valid <= 1'b1;
      r_p_rd    <= rd;
      r_p_data  <= w_sel_result;
    end else if (w_commit) begin
      r_p_valid <= 1'b0;
    end
  end

  // Register array: written only by a committing pending entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_commit) begin
      r_regs[r_p_rd] <= r_p_data;
    end
  end

  // Illegal-bundle flag: a one-cycle pulse after a rejected accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= w_accept && !w_legal;
    end
  end

  // Commit counter, wrapping naturally at its width.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_count <= '0;
    end else if (w_commit) begin
      r_wr_count <= r_wr_count + 1'b1;
    end
  end

  function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_W-1:0] a);
    logic [WIDTH-1:0] v;
    v = '0;
    if (addr_in_range(a)) begin
      if (r_p_valid && (a == r_p_rd)) begin
        v = r_p_data;
      end else begin
        v = r_regs[a];
      end
    end
`ifdef ALU_WB_ZERO_REG_EN
    if (a == '0) begin
      v = '0;
    end
`endif
    return v;
  endfunction

  // Read ports: pending data bypasses the array so readers see the newest value.
  always_comb begin
    rs_data = read_port(rs_addr);
    rt_data = read_port(rt_addr);
  end

  assign illegal_funct = r_illegal;
  assign wr_count      = r_wr_count;

endmodule
